rle_lane_expander: RTL and testbench

Parametrised run-length expansion stage for the AXI4-Stream decompression path. It consumes one RLE token per input beat ({count, value}) and emits the value (count+1) times, packed up to LANES words per output beat with a matching tkeep. It also has a per-packet bypass mode and full ready/valid backpressure on both sides. It sits between the token-extraction stage and the final concatenation stage of the decompression pipeline.

---
 rtl/decomp_pkg.sv | 33 +++
 rtl/rle_lane_expander.sv | 143 ++++++++++++++
 tb/tb_rle_lane_expander.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decomp_pkg.sv
//------------------------------------------------------------------------------
// decomp_pkg : shared types and helpers for the decompression path
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package decomp_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } rle_state_t;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_CNT_W  = 8;
    localparam int unsigned DEF_LANES  = 8;
    localparam int unsigned KEEP_W     = DEF_DATA_W * DEF_LANES / 8;
    localparam int unsigned REM_W      = DEF_CNT_W + 1;

    // Upper bound on mask width; callers size-cast the result to their own tkeep width.
    localparam int unsigned MAX_KEEP_W = 512;

    function automatic logic [MAX_KEEP_W-1:0] keep_mask(input int unsigned nbytes);
        logic [MAX_KEEP_W-1:0] m;
        for (int unsigned i = 0; i < MAX_KEEP_W; i++) begin
            m[i] = (i < nbytes);
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rle_lane_expander.sv
//------------------------------------------------------------------------------
// rle_lane_expander : expands {count,value} RLE tokens into LANES-wide beats
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rle_lane_expander
    import decomp_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned LANES  = 8
) (
    input  logic                          axis_aclk,
    input  logic                          axis_areset,
    input  logic [CNT_W+DATA_W-1:0]       s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic                          cfg_bypass,
    output logic [DATA_W*LANES-1:0]       m_axis_tdata,
    output logic [DATA_W*LANES/8-1:0]     m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [31:0]                   stat_words
);

    localparam int unsigned c_KEEP_W = DATA_W * LANES / 8;
    localparam int unsigned c_REM_W  = CNT_W + 1;
    localparam int unsigned c_OUT_W  = DATA_W * LANES;
    localparam int unsigned c_BPW    = DATA_W / 8;

    localparam logic [0:0]         c_ST_IDLE   = IDLE;
    localparam logic [0:0]         c_ST_EXPAND = EXPAND;
    localparam logic [c_REM_W-1:0] c_LANES_R   = c_REM_W'(LANES);

    logic [0:0]          r_state_q;
    logic [c_REM_W-1:0]  r_rem_q;
    logic [DATA_W-1:0]   r_value_q;
    logic                r_tok_last_q;
    logic                r_sop_q;
    logic                r_bypass_q;
    logic [c_OUT_W-1:0]  r_tdata_q;
    logic [c_KEEP_W-1:0] r_tkeep_q;
    logic                r_tvalid_q;
    logic                r_tlast_q;
    logic [31:0]         r_stat_q;

    logic                w_slot_free;
    logic                w_s_ready;
    logic                w_accept;
    logic                w_load;
    logic                w_bypass;
    logic [CNT_W-1:0]    w_count;
    logic [c_REM_W-1:0]  w_rem_src;
    logic [DATA_W-1:0]   w_val;
    logic                w_last_src;
    logic [c_REM_W-1:0]  w_k;
    logic [c_REM_W-1:0]  w_rem_d;
    logic [c_OUT_W-1:0]  w_tdata_d;
    logic [c_KEEP_W-1:0] w_tkeep_d;
    logic                w_tlast_d;
    logic [31:0]         w_stat_inc;

    assign w_slot_free = !r_tvalid_q || m_axis_tready;
    assign w_s_ready   = !axis_areset && (r_state_q == c_ST_IDLE) && w_slot_free;
    assign w_accept    = s_axis_tvalid && w_s_ready;
    assign w_load      = w_accept || ((r_state_q == c_ST_EXPAND) && w_slot_free);
    // Packet mode is taken live on the first token, latched thereafter.
    assign w_bypass    = r_sop_q ? cfg_bypass : r_bypass_q;
    assign w_count     = s_axis_tdata[CNT_W+DATA_W-1:DATA_W];
    assign w_stat_inc  = 32'($countones(r_tkeep_q)) / c_BPW;

    always_comb begin
        w_rem_src  = r_rem_q;
        w_val      = r_value_q;
        w_last_src = r_tok_last_q;
        if (w_accept) begin
            w_rem_src  = w_bypass ? c_REM_W'(1) : ({1'b0, w_count} + c_REM_W'(1));
            w_val      = s_axis_tdata[DATA_W-1:0];
            w_last_src = s_axis_tlast;
        end
        w_k = (w_rem_src > c_LANES_R) ? c_LANES_R : w_rem_src;
        w_tdata_d = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (c_REM_W'(i) < w_k) begin
                w_tdata_d[i*DATA_W +: DATA_W] = w_val;
            end
        end
        w_tkeep_d = c_KEEP_W'(keep_mask(32'(w_k) * c_BPW));
        w_tlast_d = w_last_src && (w_rem_src <= c_LANES_R);
        w_rem_d   = w_rem_src - w_k;
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            r_state_q    <= c_ST_IDLE;
            r_rem_q      <= '0;
            r_value_q    <= '0;
            r_tok_last_q <= 1'b0;
            r_sop_q      <= 1'b1;
            r_bypass_q   <= 1'b0;
            r_tdata_q    <= '0;
            r_tkeep_q    <= '0;
            r_tvalid_q   <= 1'b0;
            r_tlast_q    <= 1'b0;
            r_stat_q     <= '0;
        end else begin
            if (w_load) begin
                r_tvalid_q   <= 1'b1;
                r_tdata_q    <= w_tdata_d;
                r_tkeep_q    <= w_tkeep_d;
                r_tlast_q    <= w_tlast_d;
                r_rem_q      <= w_rem_d;
                r_value_q    <= w_val;
                r_tok_last_q <= w_last_src;
                r_state_q    <= (w_rem_d != '0) ? c_ST_EXPAND : c_ST_IDLE;
            end else if (m_axis_tready) begin
                r_tvalid_q <= 1'b0;
            end
            if (w_accept) begin
                r_sop_q <= s_axis_tlast;
                if (r_sop_q) begin
                    r_bypass_q <= cfg_bypass;
                end
            end
            if (r_tvalid_q && m_axis_tready) begin
                r_stat_q <= r_stat_q + w_stat_inc;
            end
        end
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tdata  = r_tdata_q;
    assign m_axis_tkeep  = r_tkeep_q;
    assign m_axis_tvalid = r_tvalid_q;
    assign m_axis_tlast  = r_tlast_q;
    assign stat_words    = r_stat_q;

endmodule

`default_nettype wire

// File: tb/tb_rle_lane_expander.sv
//------------------------------------------------------------------------------
// tb_rle_lane_expander : scoreboard bench for rle_lane_expander (defaults)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rle_lane_expander;

    logic         clk;
    logic         rst;
    logic [39:0]  s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic         s_tlast;
    logic         cfg_bypass;
    logic [255:0] m_tdata;
    logic [31:0]  m_tkeep;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic [31:0]  stat_words;

    rle_lane_expander #(.DATA_W(32), .CNT_W(8), .LANES(8)) dut (
        .axis_aclk     (clk),
        .axis_areset   (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .cfg_bypass    (cfg_bypass),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .stat_words    (stat_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
    } beat_t;

    beat_t       sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_beats  = 0;
    logic [31:0] exp_stat = '0;
    logic        mdl_sop  = 1'b1;
    logic        mdl_byp  = 1'b0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input int count, input logic [31:0] value, input logic last, input logic byp);
        int    n;
        int    k;
        beat_t b;
        if (mdl_sop) mdl_byp = byp;
        n = mdl_byp ? 1 : count + 1;
        while (n > 0) begin
            k = (n > 8) ? 8 : n;
            b.data = '0;
            b.keep = '0;
            for (int i = 0; i < k; i++) b.data[i*32 +: 32] = value;
            for (int j = 0; j < k*4; j++) b.keep[j] = 1'b1;
            b.last = last && (n <= 8);
            sb.push_back(b);
            n -= k;
        end
        mdl_sop = last;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge with tvalid still high.
    task automatic send_token(input int count, input logic [31:0] value, input logic last,
                              input logic byp, output int waits);
        s_tdata    = {count[7:0], value};
        s_tlast    = last;
        s_tvalid   = 1'b1;
        cfg_bypass = byp;
        waits      = 0;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            waits++;
            if (waits > 200) begin
                chk("accept_timeout", 1'b0, 1'b1);
                break;
            end
        end
        if (waits <= 200) model_push(count, value, last, byp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        s_tvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && !m_tvalid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk({tag, "_drain_timeout"}, 1'b0, 1'b1);
        chk({tag, "_stat"}, stat_words, exp_stat);
    endtask

    always @(negedge clk) begin
        beat_t b;
        int    w;
        if (!rst && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 1'b1, 1'b0);
            end else begin
                b = sb.pop_front();
                chk("beat_data", m_tdata, b.data);
                chk("beat_keep", m_tkeep, b.keep);
                chk("beat_last", m_tlast, b.last);
                chk("beat_stat", stat_words, exp_stat);
                w = 0;
                for (int j = 0; j < 32; j++) if (b.keep[j]) w++;
                exp_stat = exp_stat + 32'(w / 4);
            end
            n_beats++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int waits;
        int total;
        int base;
        logic ok;

        rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        cfg_bypass = 1'b0; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tdata",  m_tdata, 256'h0);
        chk("rst_tkeep",  m_tkeep, 32'h0);
        chk("rst_tlast",  m_tlast, 1'b0);
        chk("rst_stat",   stat_words, 32'h0);
        chk("rst_sready", s_tready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_sready", s_tready, 1'b1);
        @(posedge clk); #1;

        // Short run: one beat, three lanes
        send_token(2, 32'hA5A50001, 1'b1, 1'b0, waits);
        idle_in();
        @(negedge clk);
        chk("latency_tvalid", m_tvalid, 1'b1);
        chk("short_keep", m_tkeep, 32'h0000_0FFF);
        drain("short");
        chk("short_stat_abs", stat_words, 32'd3);

        // Multi-beat run: 20 words in three beats
        @(posedge clk); #1;
        send_token(19, 32'h1234_5678, 1'b1, 1'b0, waits);
        idle_in();
        @(negedge clk);
        chk("expand_sready_b1", s_tready, 1'b0);
        @(negedge clk);
        chk("expand_sready_b2", s_tready, 1'b0);
        drain("expand");

        // Downstream stall mid-run
        @(posedge clk); #1;
        base = n_beats;
        send_token(19, 32'hCAFE_0002, 1'b1, 1'b0, waits);
        idle_in();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (n_beats >= base + 1) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("stall_reach_b2", ok, 1'b1);
        m_tready = 1'b0;
        s_tdata = {8'd0, 32'hDEAD_BEEF}; s_tlast = 1'b1; s_tvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_tvalid", m_tvalid, 1'b1);
            if (sb.size() > 0) begin
                chk("stall_data", m_tdata, sb[0].data);
                chk("stall_keep", m_tkeep, sb[0].keep);
            end
            chk("stall_sready", s_tready, 1'b0);
            chk("stall_stat", stat_words, exp_stat);
        end
        @(posedge clk); #1;
        idle_in();
        m_tready = 1'b1;
        drain("stall");

        // Bypass packet with cfg_bypass toggled mid-packet, then a normal packet
        @(posedge clk); #1;
        send_token(200, 32'h0B0B_0001, 1'b0, 1'b1, waits);
        send_token(5,   32'h0B0B_0002, 1'b0, 1'b0, waits);
        send_token(7,   32'h0B0B_0003, 1'b1, 1'b0, waits);
        idle_in();
        drain("bypass");
        @(posedge clk); #1;
        send_token(10, 32'h0C0C_0004, 1'b1, 1'b0, waits);
        idle_in();
        drain("post_bypass");

        // Back-to-back single-word tokens
        @(posedge clk); #1;
        total = 0;
        for (int t = 0; t < 6; t++) begin
            send_token(0, 32'h7700_0000 + t, (t == 5), 1'b0, waits);
            total += waits;
        end
        idle_in();
        chk("b2b_wait_cycles", total, 0);
        drain("b2b");

        // Reset during beat 10 of a maximum run
        @(posedge clk); #1;
        base = n_beats;
        send_token(255, 32'hFEED_0255, 1'b1, 1'b0, waits);
        idle_in();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (n_beats >= base + 9) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("reset_reach_b10", ok, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_tvalid", m_tvalid, 1'b0);
        chk("midrst_stat", stat_words, 32'h0);
        chk("midrst_sready", s_tready, 1'b0);
        sb.delete();
        exp_stat = '0;
        mdl_sop  = 1'b1;
        mdl_byp  = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("release_sready", s_tready, 1'b1);
        @(posedge clk); #1;
        base = n_beats;
        send_token(255, 32'h5A5A_A5A5, 1'b1, 1'b0, waits);
        idle_in();
        drain("maxrun");
        chk("maxrun_beats", n_beats - base, 32);
        chk("maxrun_stat_abs", stat_words, 32'd256);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
